ppm_decoder: RTL and testbench

// Receive side of the VLC link. Decodes the 4-PPM optical waveform produced by ppm_encoder into one byte per frame.
// The waveform is: idle high, active-low pulses, one frame = SOF + 4 data symbols + EOF.

---
 rtl/ppm_decoder.sv | 178 +++++++++++++++++
 tb/tb_ppm_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_decoder.sv
// 4-PPM optical receiver: qualifies active-low pulses on a synchronised rx line
// and decodes one SOF + 4 symbols + EOF frame into a byte with a valid/ready handshake.
`timescale 1ns/1ps
module ppm_decoder #(
  parameter int SLOT    = 16,
  parameter int MIN_LOW = 8,
  parameter int MAX_LOW = 64,
  parameter int TOL     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int SH = $clog2(SLOT);
  localparam int TW = $clog2(40 * SLOT) + 1;
  localparam int LW = $clog2(MAX_LOW + 2);

  localparam logic signed [TW-1:0] T_ONE      = TW'(1);
  localparam logic signed [TW-1:0] T_MAX      = TW'((2 ** (TW - 1)) - 1);
  localparam logic signed [TW-1:0] T_SOF_LO   = TW'(5 * SLOT - TOL);
  localparam logic signed [TW-1:0] T_SOF_HI   = TW'(5 * SLOT + TOL);
  localparam logic signed [TW-1:0] T_DATA_GO  = TW'(-3 * SLOT + 1);
  localparam logic signed [TW-1:0] T_DATA_END = TW'(32 * SLOT);
  localparam logic signed [TW-1:0] T_EOF_LO   = TW'(33 * SLOT);
  localparam logic signed [TW-1:0] T_EOF_HI   = TW'(35 * SLOT);
  localparam logic signed [TW-1:0] T_EOF_TO   = TW'(36 * SLOT);

  typedef enum logic [2:0] {IDLE, SOF_GAP, DATA, EOF_WAIT, DELIVER} state_t;

  state_t                 state, state_n;
  logic [1:0]             sync;
  logic                   rx_s;
  logic [LW-1:0]          low_cnt;
  logic                   qual, stuck;
  logic signed [TW-1:0]   t, t_n, t_inc;
  logic                   got, got_n;
  logic [7:0]             acc, acc_n;
  logic                   err, deliver, win_end;
  logic [1:0]             sym_k, sym_v;

  assign rx_s  = sync[1];
  assign qual  = !rx_s && (low_cnt == LW'(MIN_LOW - 1));
  assign stuck = !rx_s && (low_cnt == LW'(MAX_LOW));
  assign sym_k = t[SH+4:SH+3];
  assign sym_v = t[SH+2:SH+1];
  assign busy  = (state != IDLE);

  // t is kept in edge time (current cycle minus the qualification delay), so a
  // qualified pulse is timestamped by t itself and synchroniser latency cancels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= 2'b11;
      low_cnt <= '0;
    end else begin
      sync <= {sync[0], rx};
      if (rx_s)
        low_cnt <= '0;
      else if (low_cnt != LW'(MAX_LOW + 1))
        low_cnt <= low_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    t_inc   = (t == T_MAX) ? t : t + T_ONE;
    t_n     = t_inc;
    got_n   = got;
    acc_n   = acc;
    err     = 1'b0;
    deliver = 1'b0;
    win_end = !t[TW-1] && (t != '0) && (t[SH+2:0] == '0) && (t <= T_DATA_END);
    case (state)
      IDLE: begin
        if (qual) begin
          state_n = SOF_GAP;
          t_n     = T_ONE;
        end
      end
      SOF_GAP: begin
        if (qual) begin
          if (t >= T_SOF_LO && t <= T_SOF_HI) begin
            state_n = DATA;
            t_n     = T_DATA_GO;
            got_n   = 1'b0;
            acc_n   = '0;
          end else begin
            t_n = T_ONE;
          end
        end else if (t > T_SOF_HI) begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (win_end && !got) begin
          err     = 1'b1;
          state_n = IDLE;
        end else if (win_end && t == T_DATA_END) begin
          if (qual) begin
            err     = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = EOF_WAIT;
          end
        end else begin
          if (win_end)
            got_n = 1'b0;
          // A pulse landing exactly on a window boundary belongs to the new window.
          if (qual) begin
            if (t[TW-1] || (got && !win_end)) begin
              err     = 1'b1;
              state_n = IDLE;
            end else begin
              got_n                  = 1'b1;
              acc_n[{sym_k, 1'b0} +: 2] = sym_v;
            end
          end
        end
      end
      EOF_WAIT: begin
        if (qual) begin
          if (t >= T_EOF_LO && t < T_EOF_HI) begin
            state_n = DELIVER;
          end else begin
            err     = 1'b1;
            state_n = IDLE;
          end
        end else if (t >= T_EOF_TO) begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      DELIVER: begin
        deliver = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (stuck) begin
      err     = (state != IDLE);
      deliver = 1'b0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      t          <= '0;
      got        <= 1'b0;
      acc        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      got       <= got_n;
      acc       <= acc_n;
      frame_err <= err;
      overrun   <= deliver && data_valid && !data_ready;
      if (deliver) begin
        data_out   <= acc;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed bench for ppm_decoder: frames are synthesised from an encoder model,
// table vectors cover the main decode cases, hand sequences cover timing corners.
`timescale 1ns/1ps
module tb_ppm_decoder;

  localparam int S       = 16;
  localparam int MIN_LOW = 8;
  localparam int FRAME   = 43 * S;
  localparam int NONE    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int         cyc = 0;
  int         err_cycles = 0;
  int         ovr_cycles = 0;
  int         takes = 0;
  logic [7:0] last_take = '0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  int         fall_cyc = 0;

  typedef struct {
    logic [7:0] value;
    logic       ready;
    int         drop;
    logic       glitch;
    int         skew;
    int         pre_gap;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_err;
    int         exp_ovr;
    int         exp_takes;
    logic [7:0] exp_take;
  } vec_t;

  vec_t vecs[10];

  ppm_decoder #(.SLOT(S), .MIN_LOW(MIN_LOW), .MAX_LOW(64), .TOL(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (frame_err) err_cycles <= err_cycles + 1;
    if (overrun) ovr_cycles <= ovr_cycles + 1;
    if (data_valid && data_ready) begin
      takes     <= takes + 1;
      last_take <= data_out;
    end
    if (data_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= data_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Encoder model: SOF at 0 and 5S, symbol k at 8S+8Sk+2Sv+S, EOF at 42S, each S wide.
  function automatic logic frame_low(input int c, input logic [7:0] val, input int drop,
                                     input logic glitch, input int skew);
    logic [7:0] b;
    int         st;
    logic       low;
    b   = val;
    low = (c >= 0 && c < S) || (c >= 5 * S + skew && c < 6 * S + skew) ||
          (c >= 42 * S + skew && c < 43 * S + skew);
    for (int k = 0; k < 4; k++) begin
      if (k != drop) begin
        st = 8 * S + skew + 8 * S * k + 2 * S * int'(b[2*k +: 2]) + S;
        if (c >= st && c < st + S) low = 1'b1;
      end
    end
    if (glitch && ((c >= 13 * S && c < 13 * S + 4) || (c >= 18 * S && c < 18 * S + 4)))
      low = 1'b1;
    return low;
  endfunction

  task automatic drive_frame(input logic [7:0] val, input int drop, input logic glitch,
                             input int skew, input int ncyc);
    logic nxt;
    for (int c = 0; c < ncyc; c++) begin
      nxt = !frame_low(c, val, drop, glitch, skew);
      if (rx && !nxt) fall_cyc = cyc;
      rx = nxt;
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    data_ready = v.ready;
    rx = 1'b1;
    tick(v.pre_gap);
    if (v.glitch) begin
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(S);
    end
    drive_frame(v.value, v.drop, v.glitch, v.skew, FRAME + v.skew);
    tick(2 * S);
  endtask

  initial begin
    int e0, o0, k0;

    //                value  rdy  drop  gl    skew pre   data   vld   err ovr tk take
    vecs[0] = '{8'h00, 1'b1, NONE, 1'b0,  0, 2*S, 8'h00, 1'b0, 0, 0, 1, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, NONE, 1'b0,  0, 2*S, 8'hFF, 1'b0, 0, 0, 1, 8'hFF};
    vecs[2] = '{8'h3C, 1'b1, NONE, 1'b1,  0, 2*S, 8'h3C, 1'b0, 0, 0, 1, 8'h3C};
    vecs[3] = '{8'h5A, 1'b1, 2,    1'b0,  0, 2*S, 8'h3C, 1'b0, 1, 0, 0, 8'h00};
    vecs[4] = '{8'h96, 1'b1, NONE, 1'b0,  0, 8*S, 8'h96, 1'b0, 0, 0, 1, 8'h96};
    vecs[5] = '{8'h4B, 1'b1, NONE, 1'b0,  8, 8*S, 8'h4B, 1'b0, 0, 0, 1, 8'h4B};
    vecs[6] = '{8'hE1, 1'b1, NONE, 1'b0, -8, 8*S, 8'hE1, 1'b0, 0, 0, 1, 8'hE1};
    vecs[7] = '{8'h4B, 1'b1, NONE, 1'b0,  9, 8*S, 8'hE1, 1'b0, 0, 0, 0, 8'h00};
    vecs[8] = '{8'h11, 1'b0, NONE, 1'b0,  0, 8*S, 8'h11, 1'b1, 0, 0, 0, 8'h00};
    vecs[9] = '{8'h22, 1'b0, NONE, 1'b0,  0, 2*S, 8'h22, 1'b1, 0, 1, 0, 8'h00};

    rst = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;
    tick(3);
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset overrun", overrun, 0);
    rst = 1'b1;
    tick(3);

    $display("[TB] frame 0xA5 with held handshake");
    e0 = err_cycles;
    k0 = takes;
    drive_frame(8'hA5, NONE, 1'b0, 0, FRAME);
    tick(2 * S);
    checkOutput("a5 data_out", data_out, 8'hA5);
    checkOutput("a5 data_valid", data_valid, 1);
    checkOutput("a5 frame_err", err_cycles - e0, 0);
    checkOutput("a5 latency", rise_cyc - fall_cyc, 2 + MIN_LOW - 1 + 2);
    tick(20);
    checkOutput("a5 valid held", data_valid, 1);
    data_ready = 1'b1;
    tick(1);
    checkOutput("a5 valid dropped", data_valid, 0);
    checkOutput("a5 take count", takes - k0, 1);
    checkOutput("a5 taken byte", last_take, 8'hA5);
    data_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      e0 = err_cycles;
      o0 = ovr_cycles;
      k0 = takes;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d data_out", i), data_out, vecs[i].exp_data);
      checkOutput($sformatf("v%0d data_valid", i), data_valid, vecs[i].exp_valid);
      checkOutput($sformatf("v%0d frame_err cycles", i), err_cycles - e0, vecs[i].exp_err);
      checkOutput($sformatf("v%0d overrun cycles", i), ovr_cycles - o0, vecs[i].exp_ovr);
      checkOutput($sformatf("v%0d takes", i), takes - k0, vecs[i].exp_takes);
      if (vecs[i].exp_takes > 0)
        checkOutput($sformatf("v%0d taken byte", i), last_take, vecs[i].exp_take);
    end

    data_ready = 1'b1;
    tick(2);
    checkOutput("overrun drain valid", data_valid, 0);
    checkOutput("overrun drain byte", last_take, 8'h22);
    data_ready = 1'b0;

    $display("[TB] stuck-low line");
    e0 = err_cycles;
    rx = 1'b0;
    tick(20);
    checkOutput("stuck busy early", busy, 1);
    tick(80);
    checkOutput("stuck busy late", busy, 0);
    checkOutput("stuck frame_err", err_cycles - e0, 1);
    rx = 1'b1;
    tick(4 * S);

    $display("[TB] reset mid-frame");
    drive_frame(8'h77, NONE, 1'b0, 0, 20 * S);
    checkOutput("midframe busy", busy, 1);
    rst = 1'b0;
    #2;
    checkOutput("async rst data_out", data_out, 0);
    checkOutput("async rst data_valid", data_valid, 0);
    checkOutput("async rst busy", busy, 0);
    tick(4);
    checkOutput("rst frame_err", frame_err, 0);
    rst = 1'b1;
    tick(4 * S);
    e0 = err_cycles;
    drive_frame(8'hC3, NONE, 1'b0, 0, FRAME);
    tick(2 * S);
    checkOutput("c3 data_out", data_out, 8'hC3);
    checkOutput("c3 data_valid", data_valid, 1);
    checkOutput("c3 frame_err", err_cycles - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
